// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NREQ           = 2;
    localparam int DEPTH_DEFAULT  = 64;
    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 32;

    // One-hot requester vector for a requester index.
    function automatic logic [NREQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; the caller owns and updates the pointer.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    // One-hot grant: a lone requester wins, a contest goes to prio_i.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = prio_i ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end else begin
            grant_o = 2'b00;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer in front of the single-port data memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    output logic              r0_rsp_err,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic              r1_rsp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    logic              prio_q;
    logic              owner_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_write_q;
    logic              mem_read_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [NREQ-1:0]   rsp_err_q;
    logic [NREQ-1:0]   rsp_rd_q;

    logic [NREQ-1:0]   grant_s;
    logic              arb_en_s;
    logic              sel_d;
    logic              we_d;
    logic              err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // Grants are only offered while idle and out of reset.
    assign arb_en_s = (state_q == IDLE) & ~RST;

    rr_arbiter2 u_arb (
        .valid_i  ({r1_valid, r0_valid}),
        .prio_i   (prio_q),
        .enable_i (arb_en_s),
        .grant_o  (grant_s)
    );

    assign r0_ready     = grant_s[0];
    assign r1_ready     = grant_s[1];
    assign mem_write    = mem_write_q;
    assign mem_read     = mem_read_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign r0_rsp_valid = rsp_valid_q[0];
    assign r1_rsp_valid = rsp_valid_q[1];
    assign r0_rsp_err   = rsp_err_q[0];
    assign r1_rsp_err   = rsp_err_q[1];

    // Select the granted requester's command and flag out-of-range addresses.
    always_comb begin
        sel_d = grant_s[1];
        if (sel_d) begin
            we_d    = r1_we;
            addr_d  = r1_addr;
            wdata_d = r1_wdata;
        end else begin
            we_d    = r0_we;
            addr_d  = r0_addr;
            wdata_d = r0_wdata;
        end
        err_d = (addr_d >= ADDR_W'(DEPTH));
    end

    // Memory read data arrives during RESP; pass it only to the owner of a good read.
    always_comb begin
        if (rsp_rd_q[0]) begin
            r0_rsp_rdata = mem_rdata;
        end else begin
            r0_rsp_rdata = {DATA_W{1'b0}};
        end
        if (rsp_rd_q[1]) begin
            r1_rsp_rdata = mem_rdata;
        end else begin
            r1_rsp_rdata = {DATA_W{1'b0}};
        end
    end

    // Sequencer FSM: latch on handshake, strobe memory in CMD, respond in RESP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rsp_valid_q <= {NREQ{1'b0}};
            rsp_err_q   <= {NREQ{1'b0}};
            rsp_rd_q    <= {NREQ{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= {NREQ{1'b0}};
                    rsp_err_q   <= {NREQ{1'b0}};
                    rsp_rd_q    <= {NREQ{1'b0}};
                    if (grant_s != 2'b00) begin
                        state_q     <= CMD;
                        owner_q     <= sel_d;
                        we_q        <= we_d;
                        err_q       <= err_d;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        prio_q      <= ~sel_d;
                        mem_write_q <= we_d & ~err_d;
                        mem_read_q  <= ~we_d & ~err_d;
                    end else begin
                        state_q     <= IDLE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b0;
                    end
                end
                CMD: begin
                    state_q     <= RESP;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    rsp_valid_q <= req_onehot(owner_q);
                    rsp_err_q   <= err_q ? req_onehot(owner_q) : {NREQ{1'b0}};
                    rsp_rd_q    <= (~we_q & ~err_q) ? req_onehot(owner_q) : {NREQ{1'b0}};
                end
                RESP: begin
                    state_q     <= IDLE;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    rsp_valid_q <= {NREQ{1'b0}};
                    rsp_err_q   <= {NREQ{1'b0}};
                    rsp_rd_q    <= {NREQ{1'b0}};
                end
                default: begin
                    state_q     <= IDLE;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    rsp_valid_q <= {NREQ{1'b0}};
                    rsp_err_q   <= {NREQ{1'b0}};
                    rsp_rd_q    <= {NREQ{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a 64-word registered-read memory model.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        r0_valid = 1'b0, r0_we = 1'b0;
    logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0;
    logic        r1_valid = 1'b0, r1_we = 1'b0;
    logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
    logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
    logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
        .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
        .r1_rsp_err(r1_rsp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory model: synchronous write, registered read, cleared by reset.
    logic [31:0] mem [64];
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if (mem_write && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
            if (mem_read && mem_addr < 32'd64) mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
    endtask

    typedef struct {
        logic        v0, we0; logic [31:0] a0, d0;
        logic        v1, we1; logic [31:0] a1, d1;
        logic [1:0]  g;
        logic        mw, mr;
        logic [31:0] ma, md;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vt [11];
    int   grants, rsps;
    logic owners [$];
    logic exp_owner;

    initial begin
        vt[0]  = '{1'b1, 1'b1, 32'd5,  32'hDEADBEEF, 1'b0, 1'b0, 32'd0,   32'd0,
                   2'b01, 1'b1, 1'b0, 32'd5,   32'hDEADBEEF, 1'b0, 32'd0};
        vt[1]  = '{1'b0, 1'b0, 32'd0,  32'd0,        1'b1, 1'b0, 32'd5,   32'd0,
                   2'b10, 1'b0, 1'b1, 32'd5,   32'd0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b0, 32'd64, 32'd0,        1'b0, 1'b0, 32'd0,   32'd0,
                   2'b01, 1'b0, 1'b0, 32'd64,  32'd0,        1'b1, 32'd0};
        vt[3]  = '{1'b1, 1'b1, 32'd10, 32'h12345678, 1'b1, 1'b1, 32'd11,  32'hA5A5A5A5,
                   2'b10, 1'b1, 1'b0, 32'd11,  32'hA5A5A5A5, 1'b0, 32'd0};
        vt[4]  = '{1'b1, 1'b1, 32'd10, 32'h12345678, 1'b1, 1'b0, 32'd11,  32'd0,
                   2'b01, 1'b1, 1'b0, 32'd10,  32'h12345678, 1'b0, 32'd0};
        vt[5]  = '{1'b0, 1'b0, 32'd0,  32'd0,        1'b1, 1'b0, 32'd10,  32'd0,
                   2'b10, 1'b0, 1'b1, 32'd10,  32'd0,        1'b0, 32'h12345678};
        vt[6]  = '{1'b1, 1'b0, 32'd11, 32'd0,        1'b0, 1'b0, 32'd0,   32'd0,
                   2'b01, 1'b0, 1'b1, 32'd11,  32'd0,        1'b0, 32'hA5A5A5A5};
        vt[7]  = '{1'b1, 1'b1, 32'd63, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0,   32'd0,
                   2'b01, 1'b1, 1'b0, 32'd63,  32'hCAFEF00D, 1'b0, 32'd0};
        vt[8]  = '{1'b0, 1'b0, 32'd0,  32'd0,        1'b1, 1'b0, 32'd63,  32'd0,
                   2'b10, 1'b0, 1'b1, 32'd63,  32'd0,        1'b0, 32'hCAFEF00D};
        vt[9]  = '{1'b0, 1'b0, 32'd0,  32'd0,        1'b1, 1'b1, 32'd100, 32'd55,
                   2'b10, 1'b0, 1'b0, 32'd100, 32'd55,       1'b1, 32'd0};
        vt[10] = '{1'b1, 1'b0, 32'd3,  32'd0,        1'b0, 1'b0, 32'd0,   32'd0,
                   2'b01, 1'b0, 1'b1, 32'd3,   32'd0,        1'b0, 32'd0};

        // Reset state, with a request already pending
        r0_valid = 1'b1;
        step();
        chk("rst_ready0", 32'(r0_ready), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_valid", 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
        chk("rst_rsp_rdata", r0_rsp_rdata | r1_rsp_rdata, 32'd0);
        RST = 1'b0;
        #1;
        chk("post_rst_ready0", 32'(r0_ready), 32'd1);
        r0_valid = 1'b0;
        step();

        // Table-driven single transactions
        for (int i = 0; i < 11; i++) begin
            r0_valid = vt[i].v0; r0_we = vt[i].we0; r0_addr = vt[i].a0; r0_wdata = vt[i].d0;
            r1_valid = vt[i].v1; r1_we = vt[i].we1; r1_addr = vt[i].a1; r1_wdata = vt[i].d1;
            #1;
            chk($sformatf("v%0d_ready", i), 32'({r1_ready, r0_ready}), 32'(vt[i].g));
            step();
            r0_valid = 1'b0;
            r1_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_cmd_ready", i), 32'({r1_ready, r0_ready}), 32'd0);
            chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vt[i].mw));
            chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(vt[i].mr));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].ma);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].md);
            chk($sformatf("v%0d_cmd_rsp", i), 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
            step();
            chk($sformatf("v%0d_rsp_valid", i), 32'({r1_rsp_valid, r0_rsp_valid}), 32'(vt[i].g));
            chk($sformatf("v%0d_rsp_err", i), 32'({r1_rsp_err, r0_rsp_err}),
                vt[i].err ? 32'(vt[i].g) : 32'd0);
            chk($sformatf("v%0d_r0_rdata", i), r0_rsp_rdata, vt[i].g[0] ? vt[i].rd : 32'd0);
            chk($sformatf("v%0d_r1_rdata", i), r1_rsp_rdata, vt[i].g[1] ? vt[i].rd : 32'd0);
            chk($sformatf("v%0d_rsp_mem_strobe", i), 32'({mem_write, mem_read}), 32'd0);
            step();
            chk($sformatf("v%0d_rsp_done", i), 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
        end

        // Reset during CMD of an r1 write: transaction dropped
        r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 32'd3; r1_wdata = 32'd7;
        #1;
        chk("rstcmd_ready1", 32'(r1_ready), 32'd1);
        step();
        r1_valid = 1'b0;
        chk("rstcmd_mem_write", 32'(mem_write), 32'd1);
        RST = 1'b1;
        #1;
        chk("rstcmd_mem_write_clr", 32'(mem_write), 32'd0);
        chk("rstcmd_mem_addr_clr", mem_addr, 32'd0);
        chk("rstcmd_mem_wdata_clr", mem_wdata, 32'd0);
        chk("rstcmd_rsp_clr", 32'({r1_rsp_valid, r0_rsp_valid, r1_rsp_err, r0_rsp_err}), 32'd0);
        step();
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rstcmd_no_rsp", 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
        end
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 32'd3;
        #1;
        chk("rstcmd_rd_ready0", 32'(r0_ready), 32'd1);
        step();
        r0_valid = 1'b0;
        chk("rstcmd_rd_mem_read", 32'(mem_read), 32'd1);
        step();
        chk("rstcmd_rd_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        chk("rstcmd_rd_rdata", r0_rsp_rdata, 32'd0);
        step();

        // Fairness: both requesters continuously valid from reset
        do_reset();
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 32'd0;
        r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 32'd1;
        grants = 0;
        rsps = 0;
        for (int c = 0; c < 40 && !(grants == 6 && rsps == 6); c++) begin
            #1;
            if (r0_ready || r1_ready) begin
                chk("fair_grant", 32'({r1_ready, r0_ready}), (grants % 2 == 0) ? 32'd1 : 32'd2);
                owners.push_back(r1_ready);
                grants++;
            end
            if (r0_rsp_valid || r1_rsp_valid) begin
                if (owners.size() > 0) begin
                    exp_owner = owners.pop_front();
                    chk("fair_rsp_owner", 32'({r1_rsp_valid, r0_rsp_valid}),
                        exp_owner ? 32'd2 : 32'd1);
                end else begin
                    chk("fair_rsp_unexpected", 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
                end
                rsps++;
            end
            step();
            if (grants == 6) begin
                r0_valid = 1'b0;
                r1_valid = 1'b0;
            end
        end
        chk("fair_grant_count", 32'(grants), 32'd6);
        chk("fair_rsp_count", 32'(rsps), 32'd6);
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // r1 alone three times, then a contest goes to r0
        do_reset();
        r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 32'd2;
        r0_we = 1'b0; r0_addr = 32'd4;
        grants = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            #1;
            if (r0_ready || r1_ready) begin
                chk("solo_grant", 32'({r1_ready, r0_ready}), (grants < 3) ? 32'd2 : 32'd1);
                grants++;
            end
            step();
            if (grants == 3) r0_valid = 1'b1;
        end
        chk("solo_grant_count", 32'(grants), 32'd4);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-port 64-word data memory. Accepts word read/write requests from requester 0 (CPU load/store path) and requester 1 (debug/DMA loader) over valid/ready handshakes. Drives the memory's MemWrite/MemRead/Address/Write_data strobes one transaction at a time, and returns exactly one response pulse per accepted request.

## Interface
- DEPTH, 64, memory words; word addresses ≥ DEPTH are rejected
- DATA_W, 32, data width
- ADDR_W, 32, request/memory address width, word-indexed
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- r0_valid / r1_valid  in  1  request present
- r0_ready / r1_ready  out  1  request accepted this cycle when valid&ready
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  ADDR_W  word address
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_rsp_valid / r1_rsp_valid  out  1  one-cycle response pulse
- r0_rsp_rdata / r1_rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads; 0 on writes and errors
- r0_rsp_err / r1_rsp_err  out  1  address out of range, valid with rsp_valid
- mem_write  out  1  to memory MemWrite
- mem_read  out  1  to memory MemRead
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_data
- mem_rdata  in  DATA_W  from memory Read_data; registered, valid the cycle after a mem_read edge

## Operation
- FSM states: IDLE, CMD, RESP. Transitions: IDLE→CMD on handshake; CMD→RESP unconditionally; RESP→IDLE unconditionally.
- IDLE: the grant is computed combinationally from r*_valid and the priority pointer `prio`.
  - Both valid → grant the requester named by `prio`.
  - One valid → grant that requester.
  - Only the granted requester sees ready=1. Ready is low in CMD and RESP.
- On handshake: latch owner, we, addr, wdata. Set err = (addr ≥ DEPTH). Set `prio` to the non-granted requester.
- CMD: mem_addr/mem_wdata = latched values.
  - mem_write = we & !err; mem_read = !we & !err.
  - Never both high. Both low outside CMD and on error.
- RESP: owner's rsp_valid=1, rsp_err=err.
  - rsp_rdata = mem_rdata for a successful read, else 0.
  - Non-owner outputs stay 0.
- Ready/valid: the requester must hold valid/we/addr/wdata stable until ready. Dropping valid before the handshake is legal and forfeits the request.

## Timing
- Handshake in cycle N → memory strobes in N+1 → rsp_valid in N+2 → next handshake no earlier than N+3. Throughput is 1 transaction per 3 cycles.
- Write data lands in memory at the end of N+1. A read issued in the next transaction returns the new value.
- Reset values:
  - state=IDLE, prio=0, all latches 0.
  - All mem_* = 0; all rsp_valid/rsp_err/rsp_rdata = 0.
  - ready follows IDLE logic once RST deasserts.
- RST in CMD or RESP: the transaction is dropped and no response is issued. Memory contents are cleared by the memory's own reset.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Out-of-range requests take the same 3-cycle slot and do not touch memory.

## Structure
- Package dmem_arb_pkg holds:
  - state enum {IDLE, CMD, RESP}
  - NREQ=2
  - DEPTH default constant
- Sub-module rr_arbiter2:
  - Inputs: valid[1:0], prio, enable.
  - Outputs: one-hot grant[1:0], combinational.
  - Parent updates `prio`.
- Top holds the FSM, request latch and response demux. Target ~150–250 lines.

## Test plan
- Reset, then r0 write addr 5 data 0xDEADBEEF.
  - mem_write=1, mem_addr=5 exactly one cycle after handshake.
  - r0_rsp_valid two cycles after, rsp_err=0.
  - r1 outputs stay 0.
- r1 read addr 5 after the write above → r1_rsp_valid with r1_rsp_rdata=0xDEADBEEF, two cycles after handshake.
- r0 and r1 both valid continuously for 6 transactions from reset → grant order 0,1,0,1,0,1; each response goes only to its owner.
- r0 read addr 64 (DEPTH) → mem_read/mem_write stay 0; r0_rsp_valid with rsp_err=1, rdata=0.
- Assert RST during CMD of an r1 write addr 3 data 7.
  - No rsp_valid; all outputs 0 immediately.
  - After release, read addr 3 returns 0.
- Only r1 valid for 3 requests, then both valid → r1 granted each time; the next contested grant goes to r0.
